id_stage: RTL

Decode/issue stage of the RV32I pipeline. It accepts instruction words from fetch, decodes them to the 5-bit `optype` code and operand set consumed by `exe`, and reads the register file with write-back bypass. It detects load-use hazards and stalls fetch for one bubble, and drops wrong-path instructions when `exe` asserts `clr`. The outputs form the ID/EX pipeline register feeding `exe` directly.

---
 rtl/rv_pkg.sv | 84 ++++++++
 rtl/id_decode.sv | 156 +++++++++++++++
 rtl/id_stage.sv | 103 ++++++++++
 3 files changed

// File: rtl/rv_pkg.sv
// Shared RV32I definitions: optype codes, opcode/funct fields, and the ID/EX bundle.
package rv_pkg;

  localparam int OPT_W = 5;

  localparam logic [OPT_W-1:0] OPT_NOP   = 5'd0;
  localparam logic [OPT_W-1:0] OPT_ADD   = 5'd1;
  localparam logic [OPT_W-1:0] OPT_SUB   = 5'd2;
  localparam logic [OPT_W-1:0] OPT_AND   = 5'd3;
  localparam logic [OPT_W-1:0] OPT_OR    = 5'd4;
  localparam logic [OPT_W-1:0] OPT_XOR   = 5'd5;
  localparam logic [OPT_W-1:0] OPT_SLL   = 5'd6;
  localparam logic [OPT_W-1:0] OPT_SRL   = 5'd7;
  localparam logic [OPT_W-1:0] OPT_SRA   = 5'd8;
  localparam logic [OPT_W-1:0] OPT_SLT   = 5'd9;
  localparam logic [OPT_W-1:0] OPT_SLTU  = 5'd10;
  localparam logic [OPT_W-1:0] OPT_ADDI  = 5'd11;
  localparam logic [OPT_W-1:0] OPT_ANDI  = 5'd12;
  localparam logic [OPT_W-1:0] OPT_ORI   = 5'd13;
  localparam logic [OPT_W-1:0] OPT_XORI  = 5'd14;
  localparam logic [OPT_W-1:0] OPT_SLTI  = 5'd15;
  localparam logic [OPT_W-1:0] OPT_SLTIU = 5'd16;
  localparam logic [OPT_W-1:0] OPT_SLLI  = 5'd17;
  localparam logic [OPT_W-1:0] OPT_SRLI  = 5'd18;
  localparam logic [OPT_W-1:0] OPT_SRAI  = 5'd19;
  localparam logic [OPT_W-1:0] OPT_LUI   = 5'd20;
  localparam logic [OPT_W-1:0] OPT_AUIPC = 5'd21;
  localparam logic [OPT_W-1:0] OPT_JAL   = 5'd22;
  localparam logic [OPT_W-1:0] OPT_JALR  = 5'd23;
  localparam logic [OPT_W-1:0] OPT_BEQ   = 5'd24;
  localparam logic [OPT_W-1:0] OPT_BNE   = 5'd25;
  localparam logic [OPT_W-1:0] OPT_BLT   = 5'd26;
  localparam logic [OPT_W-1:0] OPT_BGE   = 5'd27;
  localparam logic [OPT_W-1:0] OPT_BLTU  = 5'd28;
  localparam logic [OPT_W-1:0] OPT_BGEU  = 5'd29;
  localparam logic [OPT_W-1:0] OPT_LW    = 5'd30;
  localparam logic [OPT_W-1:0] OPT_SW    = 5'd31;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;

  localparam logic [2:0] F3_ADD_SUB = 3'b000;
  localparam logic [2:0] F3_SLL     = 3'b001;
  localparam logic [2:0] F3_SLT     = 3'b010;
  localparam logic [2:0] F3_SLTU    = 3'b011;
  localparam logic [2:0] F3_XOR     = 3'b100;
  localparam logic [2:0] F3_SRL_SRA = 3'b101;
  localparam logic [2:0] F3_OR      = 3'b110;
  localparam logic [2:0] F3_AND     = 3'b111;
  localparam logic [2:0] F3_BEQ     = 3'b000;
  localparam logic [2:0] F3_BNE     = 3'b001;
  localparam logic [2:0] F3_BLT     = 3'b100;
  localparam logic [2:0] F3_BGE     = 3'b101;
  localparam logic [2:0] F3_BLTU    = 3'b110;
  localparam logic [2:0] F3_BGEU    = 3'b111;
  localparam logic [2:0] F3_WORD    = 3'b010;
  localparam logic [2:0] F3_JALR    = 3'b000;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  typedef struct packed {
    logic [OPT_W-1:0] optype;
    logic [31:0]      data1;
    logic [31:0]      data2;
    logic [31:0]      immediate;
    logic [31:0]      offset;
    logic [31:0]      ins_addr;
    logic [4:0]       rd;
    logic             valid;
  } idex_t;

  localparam idex_t IDEX_NOP = '0;

  typedef enum logic {ST_RUN, ST_STALL} id_state_e;

endpackage

// File: rtl/id_decode.sv
// Combinational RV32I decoder: optype, immediates and register fields for the ID stage.
module id_decode
  import rv_pkg::*;
(
  input  logic [31:0]      ins,
  output logic [OPT_W-1:0] optype,
  output logic [31:0]      immediate,
  output logic [31:0]      offset,
  output logic [4:0]       rs1,
  output logic [4:0]       rs2,
  output logic [4:0]       rd,
  output logic             uses_rs1,
  output logic             uses_rs2
);

  logic [6:0]  opcode;
  logic [2:0]  f3;
  logic [6:0]  f7;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j, imm_sh;
  logic        has_rd;

  assign opcode = ins[6:0];
  assign f3     = ins[14:12];
  assign f7     = ins[31:25];

  assign imm_i  = {{20{ins[31]}}, ins[31:20]};
  assign imm_s  = {{20{ins[31]}}, ins[31:25], ins[11:7]};
  assign imm_b  = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
  assign imm_u  = {ins[31:12], 12'b0};
  assign imm_j  = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
  assign imm_sh = {27'b0, ins[24:20]};

  always_comb begin
    // NOTE: every output gets a default first so no path through the case leaves a latch.
    optype    = OPT_NOP;
    immediate = '0;
    offset    = '0;
    uses_rs1  = 1'b0;
    uses_rs2  = 1'b0;
    has_rd    = 1'b0;
    case (opcode)
      OPC_OP: begin
        has_rd   = 1'b1;
        uses_rs1 = 1'b1;
        uses_rs2 = 1'b1;
        if (f7 == F7_BASE) begin
          case (f3)
            F3_ADD_SUB: optype = OPT_ADD;
            F3_SLL:     optype = OPT_SLL;
            F3_SLT:     optype = OPT_SLT;
            F3_SLTU:    optype = OPT_SLTU;
            F3_XOR:     optype = OPT_XOR;
            F3_SRL_SRA: optype = OPT_SRL;
            F3_OR:      optype = OPT_OR;
            F3_AND:     optype = OPT_AND;
            default:    optype = OPT_NOP;
          endcase
        end else if (f7 == F7_ALT) begin
          if (f3 == F3_ADD_SUB)      optype = OPT_SUB;
          else if (f3 == F3_SRL_SRA) optype = OPT_SRA;
        end
      end
      OPC_OP_IMM: begin
        has_rd    = 1'b1;
        uses_rs1  = 1'b1;
        immediate = imm_i;
        case (f3)
          F3_ADD_SUB: optype = OPT_ADDI;
          F3_SLT:     optype = OPT_SLTI;
          F3_SLTU:    optype = OPT_SLTIU;
          F3_XOR:     optype = OPT_XORI;
          F3_OR:      optype = OPT_ORI;
          F3_AND:     optype = OPT_ANDI;
          F3_SLL: begin
            immediate = imm_sh;
            if (f7 == F7_BASE) optype = OPT_SLLI;
          end
          F3_SRL_SRA: begin
            immediate = imm_sh;
            if (f7 == F7_BASE)     optype = OPT_SRLI;
            else if (f7 == F7_ALT) optype = OPT_SRAI;
          end
          default: optype = OPT_NOP;
        endcase
      end
      OPC_LUI: begin
        has_rd    = 1'b1;
        immediate = imm_u;
        optype    = OPT_LUI;
      end
      OPC_AUIPC: begin
        has_rd    = 1'b1;
        immediate = imm_u;
        optype    = OPT_AUIPC;
      end
      OPC_JAL: begin
        has_rd = 1'b1;
        offset = imm_j;
        optype = OPT_JAL;
      end
      OPC_JALR: begin
        if (f3 == F3_JALR) begin
          has_rd    = 1'b1;
          uses_rs1  = 1'b1;
          immediate = imm_i;
          optype    = OPT_JALR;
        end
      end
      OPC_BRANCH: begin
        uses_rs1 = 1'b1;
        uses_rs2 = 1'b1;
        offset   = imm_b;
        case (f3)
          F3_BEQ:  optype = OPT_BEQ;
          F3_BNE:  optype = OPT_BNE;
          F3_BLT:  optype = OPT_BLT;
          F3_BGE:  optype = OPT_BGE;
          F3_BLTU: optype = OPT_BLTU;
          F3_BGEU: optype = OPT_BGEU;
          default: optype = OPT_NOP;
        endcase
      end
      OPC_LOAD: begin
        if (f3 == F3_WORD) begin
          has_rd    = 1'b1;
          uses_rs1  = 1'b1;
          immediate = imm_i;
          optype    = OPT_LW;
        end
      end
      OPC_STORE: begin
        if (f3 == F3_WORD) begin
          uses_rs1  = 1'b1;
          uses_rs2  = 1'b1;
          immediate = imm_s;
          optype    = OPT_SW;
        end
      end
      default: optype = OPT_NOP;
    endcase

    // Illegal encodings collapse to a clean NOP with no register traffic.
    if (optype == OPT_NOP) begin
      immediate = '0;
      offset    = '0;
      uses_rs1  = 1'b0;
      uses_rs2  = 1'b0;
      has_rd    = 1'b0;
    end
  end

  assign rs1 = uses_rs1 ? ins[19:15] : 5'd0;
  assign rs2 = uses_rs2 ? ins[24:20] : 5'd0;
  assign rd  = has_rd   ? ins[11:7]  : 5'd0;

endmodule

// File: rtl/id_stage.sv
// RV32I decode/issue stage: ID/EX pipeline register, write-back bypass, load-use stall, flush.
module id_stage
  import rv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             if_valid,
  input  logic [31:0]      if_ins,
  input  logic [XLEN-1:0]  if_addr,
  output logic             id_ready,
  output logic [4:0]       rs1_addr,
  output logic [4:0]       rs2_addr,
  input  logic [XLEN-1:0]  rs1_data,
  input  logic [XLEN-1:0]  rs2_data,
  input  logic             wb_en,
  input  logic [4:0]       wb_rd,
  input  logic [XLEN-1:0]  wb_data,
  input  logic             clr,
  output logic [OPT_W-1:0] optype,
  output logic [XLEN-1:0]  data1,
  output logic [XLEN-1:0]  data2,
  output logic [XLEN-1:0]  immediate,
  output logic [XLEN-1:0]  offset,
  output logic [XLEN-1:0]  ins_addr,
  output logic [4:0]       rd,
  output logic             id_valid
);

  logic [OPT_W-1:0] dec_optype;
  logic [31:0]      dec_imm, dec_off;
  logic [4:0]       dec_rd;
  logic             dec_uses_rs1, dec_uses_rs2;
  logic [31:0]      op1, op2;
  logic             hazard;
  idex_t            q, d;
  id_state_e        state_q, state_d;

  id_decode u_decode (
    .ins       (if_ins),
    .optype    (dec_optype),
    .immediate (dec_imm),
    .offset    (dec_off),
    .rs1       (rs1_addr),
    .rs2       (rs2_addr),
    .rd        (dec_rd),
    .uses_rs1  (dec_uses_rs1),
    .uses_rs2  (dec_uses_rs2)
  );

  // x0 is hard zero; a same-cycle write-back overrides the stale register-file read.
  function automatic logic [31:0] read_operand(input logic [4:0] addr, input logic [31:0] rf,
                                               input logic en, input logic [4:0] wrd,
                                               input logic [31:0] wdata);
    if (addr == 5'd0)              return '0;
    else if (en && wrd == addr)    return wdata;
    else                           return rf;
  endfunction

  assign op1 = read_operand(rs1_addr, rs1_data, wb_en, wb_rd, wb_data);
  assign op2 = read_operand(rs2_addr, rs2_data, wb_en, wb_rd, wb_data);

  assign hazard = if_valid && (q.optype == OPT_LW) && (q.rd != 5'd0) &&
                  ((dec_uses_rs1 && rs1_addr != 5'd0 && rs1_addr == q.rd) ||
                   (dec_uses_rs2 && rs2_addr != 5'd0 && rs2_addr == q.rd));

  always_comb begin
    state_d  = state_q;
    d        = IDEX_NOP;
    id_ready = 1'b1;
    if (clr) begin
      state_d = ST_RUN;
    end else if (state_q == ST_RUN && hazard) begin
      id_ready = 1'b0;
      state_d  = ST_STALL;
    end else begin
      state_d = ST_RUN;
      if (if_valid) d = '{dec_optype, op1, op2, dec_imm, dec_off, if_addr, dec_rd, 1'b1};
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: reset is synchronous and active-low, so it is tested only inside the clocked branch.
    if (!rst) begin
      state_q <= ST_RUN;
      q       <= IDEX_NOP;
    end else begin
      state_q <= state_d;
      q       <= d;
    end
  end

  assign optype    = q.optype;
  assign data1     = q.data1;
  assign data2     = q.data2;
  assign immediate = q.immediate;
  assign offset    = q.offset;
  assign ins_addr  = q.ins_addr;
  assign rd        = q.rd;
  assign id_valid  = q.valid;

endmodule
